// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle unsigned A-B, CHUNK bits per clock with a registered borrow
module chunked_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_sub1,
    input  logic [WIDTH-1:0] i_sub2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_borrow
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic borrow;
    logic [WIDTH-1:0] a, b;
    logic [CHUNK:0] diff;
    logic last;

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("chunked_subtractor: WIDTH must be a positive multiple of CHUNK");
    end

    assign o_ready = state == IDLE;
    assign o_valid = state == DONE;
    assign last = idx == IW'(NUM_CHUNKS - 1);
    assign diff = {1'b0, a[idx*CHUNK +: CHUNK]} - {1'b0, b[idx*CHUNK +: CHUNK]} - (CHUNK+1)'(borrow);

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next state; the unused encoding falls back to IDLE behaviour
    always_comb begin
        state_nx = (state == CALC) ? (last ? DONE : CALC) :
                   (state == DONE) ? (i_ready ? IDLE : DONE) :
                   (i_valid ? CALC : IDLE);
    end

    // operand capture, then one slice of the difference per CALC cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a <= '0;
            b <= '0;
            idx <= '0;
            borrow <= 1'b0;
            o_result <= '0;
            o_borrow <= 1'b0;
        end else if (state == CALC) begin
            o_result[idx*CHUNK +: CHUNK] <= diff[CHUNK-1:0];
            borrow <= diff[CHUNK];
            o_borrow <= diff[CHUNK];
            idx <= last ? '0 : idx + 1'b1;
        end else if (state != DONE && i_valid) begin
            a <= i_sub1;
            b <= i_sub2;
            borrow <= 1'b0;
            idx <= '0;
        end
    end
endmodule
